// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl: walks every set/way, writes back dirty lines and invalidates valid lines; DCACHE_FLUSH_STATS_EN adds a dirty writeback counter
module dcache_flush_ctrl #(
  parameter int NumSets = 256,
  parameter int NumWays = 8,
  localparam int IdxW = $clog2(NumSets),
  localparam int WayW = $clog2(NumWays)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_req_i,
  output logic            flush_ack_o,
  output logic            busy_o,
  output logic            tag_req_o,
  input  logic            tag_gnt_i,
  output logic [IdxW-1:0] tag_idx_o,
  output logic [WayW-1:0] tag_way_o,
  input  logic            tag_rvalid_i,
  input  logic            tag_valid_i,
  input  logic            tag_dirty_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  input  logic            wb_done_i,
  output logic            inv_o,
  output logic [15:0]     dirty_cnt_o
);
  typedef enum logic [2:0] {IDLE, READ_TAG, WAIT_TAG, WRITEBACK, WAIT_WB, INVALIDATE, DONE} state_e;
  state_e state_q, state_d;
  logic [IdxW-1:0] set_q, set_d;
  logic [WayW-1:0] way_q, way_d;
  logic last, adv, start;
  logic ack_q, busy_q, tag_req_q, wb_valid_q, inv_q;
  assign last  = set_q == IdxW'(NumSets - 1) && way_q == WayW'(NumWays - 1);
  assign adv   = state_q == INVALIDATE || (state_q == WAIT_TAG && tag_rvalid_i && !tag_valid_i);
  assign start = state_q == IDLE && flush_req_i;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = flush_req_i ? READ_TAG : IDLE;
      READ_TAG:   state_d = tag_gnt_i ? WAIT_TAG : READ_TAG;
      WAIT_TAG:   state_d = !tag_rvalid_i ? WAIT_TAG : !tag_valid_i ? (last ? DONE : READ_TAG) :
                            tag_dirty_i ? WRITEBACK : INVALIDATE;
      WRITEBACK:  state_d = wb_ready_i ? WAIT_WB : WRITEBACK;
      WAIT_WB:    state_d = wb_done_i ? INVALIDATE : WAIT_WB;
      INVALIDATE: state_d = last ? DONE : READ_TAG;
      default:    state_d = IDLE;
    endcase
    {set_d, way_d} = start ? '0 : (adv && !last) ? {set_q, way_q} + (IdxW + WayW)'(1) : {set_q, way_q};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      set_q      <= '0;
      way_q      <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      tag_req_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      way_q      <= way_d;
      ack_q      <= state_d == DONE;
      busy_q     <= state_d != IDLE;
      tag_req_q  <= state_d == READ_TAG;
      wb_valid_q <= state_d == WRITEBACK;
      inv_q      <= state_d == INVALIDATE;
    end
  end
  assign flush_ack_o = ack_q;
  assign busy_o      = busy_q;
  assign tag_req_o   = tag_req_q;
  assign wb_valid_o  = wb_valid_q;
  assign inv_o       = inv_q;
  assign tag_idx_o   = set_q;
  assign tag_way_o   = way_q;
`ifdef DCACHE_FLUSH_STATS_EN
  logic [15:0] dirty_q, dirty_d;
  always_comb dirty_d = start ? '0 : (state_q == WRITEBACK && wb_ready_i && dirty_q != '1) ? dirty_q + 16'd1 : dirty_q;
  always_ff @(posedge clk_i) dirty_q <= rst_i ? '0 : dirty_d;
  assign dirty_cnt_o = dirty_q;
`else
  assign dirty_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// tb_dcache_flush_ctrl: directed checks of the flush walk on a 4-set 2-way cache
module tb_dcache_flush_ctrl;
  logic clk = 1'b0;
  logic rst_i, flush_req_i, tag_gnt_i, tag_rvalid_i, tag_valid_i, tag_dirty_i, wb_ready_i, wb_done_i;
  logic flush_ack_o, busy_o, tag_req_o, wb_valid_o, inv_o;
  logic [1:0] tag_idx_o;
  logic [0:0] tag_way_o;
  logic [15:0] dirty_cnt_o;
  logic [7:0] lv, ld;
  int n_chk = 0, n_fail = 0;
  int reads, rd_bad, invs, inv_bad, inv_cyc, wbs, wb_bad, wb_cyc, acks, ack1, ack2, idle1, stall, post_rst;
`ifdef DCACHE_FLUSH_STATS_EN
  localparam logic [15:0] DC1 = 16'd1;
`else
  localparam logic [15:0] DC1 = 16'd0;
`endif
  always #5 clk = ~clk;
  dcache_flush_ctrl #(.NumSets(4), .NumWays(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o), .busy_o(busy_o),
    .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i), .tag_idx_o(tag_idx_o), .tag_way_o(tag_way_o),
    .tag_rvalid_i(tag_rvalid_i), .tag_valid_i(tag_valid_i), .tag_dirty_i(tag_dirty_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_done_i(wb_done_i), .inv_o(inv_o),
    .dirty_cnt_o(dirty_cnt_o));
  always @(posedge clk) begin
    tag_rvalid_i <= !rst_i && tag_req_o && tag_gnt_i;
    tag_valid_i  <= lv[{tag_idx_o, tag_way_o}];
    tag_dirty_i  <= ld[{tag_idx_o, tag_way_o}];
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic walk(input int n, rq_b, rq2, g_a, g_b, wr, wd, rs);
    logic [2:0] lr;
    lr = '0;
    reads = 0; rd_bad = 0; invs = 0; inv_bad = 0; inv_cyc = -1; wbs = 0; wb_bad = 0; wb_cyc = -1;
    acks = 0; ack1 = -1; ack2 = -1; idle1 = -1; stall = 0; post_rst = 0;
    for (int c = 0; c <= n; c++) begin
      flush_req_i = c <= rq_b || c == rq2;
      tag_gnt_i   = !(c >= g_a && c <= g_b);
      wb_ready_i  = c == wr;
      wb_done_i   = c == wd;
      rst_i       = c == rs;
      if (tag_req_o && tag_gnt_i) begin
        if ({tag_idx_o, tag_way_o} != 3'(reads)) rd_bad++;
        lr = {tag_idx_o, tag_way_o};
        reads++;
      end
      if (tag_req_o && !tag_gnt_i && {tag_idx_o, tag_way_o} == 3'(reads)) stall++;
      if (inv_o) begin
        if ({tag_idx_o, tag_way_o} != lr) inv_bad++;
        if (inv_cyc < 0) inv_cyc = c;
        invs++;
      end
      if (wb_valid_o) begin
        if ({tag_idx_o, tag_way_o} != lr) wb_bad++;
        if (wb_cyc < 0) wb_cyc = c;
        wbs++;
      end
      if (flush_ack_o) begin
        acks++;
        if (ack1 < 0) ack1 = c; else if (ack2 < 0) ack2 = c;
      end
      if (!busy_o && ack1 >= 0 && idle1 < 0) idle1 = c;
      if (rs >= 0 && c > rs && (busy_o || tag_req_o || wb_valid_o || inv_o || flush_ack_o ||
          tag_idx_o != 0 || tag_way_o != 0 || dirty_cnt_o != 0)) post_rst++;
      step();
    end
    flush_req_i = 0; tag_gnt_i = 1; wb_ready_i = 0; wb_done_i = 0; rst_i = 0;
  endtask
  task automatic test_reset();
    rst_i = 1; flush_req_i = 1; tag_gnt_i = 1; wb_ready_i = 0; wb_done_i = 0; lv = '0; ld = '0;
    step(); step();
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_chk++; if (flush_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", flush_ack_o); end
    n_chk++; if (tag_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_tag_req: got %b want 0", tag_req_o); end
    n_chk++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid_o); end
    n_chk++; if (inv_o !== 1'b0) begin n_fail++; $display("FAIL rst_inv: got %b want 0", inv_o); end
    n_chk++; if ({tag_idx_o, tag_way_o} !== 3'd0) begin n_fail++; $display("FAIL rst_idx_way: got %0d want 0", {tag_idx_o, tag_way_o}); end
    n_chk++; if (dirty_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_dirty_cnt: got %0d want 0", dirty_cnt_o); end
    rst_i = 0; flush_req_i = 0;
    step();
  endtask
  task automatic test_invalid();
    lv = '0; ld = '0;
    walk(20, 0, -1, -1, -1, -1, -1, -1);
    n_chk++; if (reads !== 8) begin n_fail++; $display("FAIL inval_reads: got %0d want 8", reads); end
    n_chk++; if (rd_bad !== 0) begin n_fail++; $display("FAIL inval_order: got %0d bad reads want 0", rd_bad); end
    n_chk++; if (invs + wbs !== 0) begin n_fail++; $display("FAIL inval_no_inv_wb: got %0d want 0", invs + wbs); end
    n_chk++; if (ack1 !== 17) begin n_fail++; $display("FAIL inval_ack_cycle: got %0d want 17", ack1); end
    n_chk++; if (idle1 !== 18) begin n_fail++; $display("FAIL inval_idle_cycle: got %0d want 18", idle1); end
  endtask
  task automatic test_clean();
    lv = '1; ld = '0;
    walk(28, 0, -1, -1, -1, -1, -1, -1);
    n_chk++; if (reads !== 8) begin n_fail++; $display("FAIL clean_reads: got %0d want 8", reads); end
    n_chk++; if (invs !== 8) begin n_fail++; $display("FAIL clean_invs: got %0d want 8", invs); end
    n_chk++; if (inv_bad !== 0) begin n_fail++; $display("FAIL clean_inv_addr: got %0d bad want 0", inv_bad); end
    n_chk++; if (wbs !== 0) begin n_fail++; $display("FAIL clean_wbs: got %0d want 0", wbs); end
    n_chk++; if (ack1 !== 25) begin n_fail++; $display("FAIL clean_ack_cycle: got %0d want 25", ack1); end
    n_chk++; if (dirty_cnt_o !== 16'd0) begin n_fail++; $display("FAIL clean_dirty_cnt: got %0d want 0", dirty_cnt_o); end
  endtask
  task automatic test_dirty();
    lv = '0; ld = '0; lv[5] = 1'b1; ld[5] = 1'b1;
    walk(30, 0, -1, -1, -1, 16, 20, -1);
    n_chk++; if (wbs !== 4) begin n_fail++; $display("FAIL dirty_wb_len: got %0d want 4", wbs); end
    n_chk++; if (wb_cyc !== 13) begin n_fail++; $display("FAIL dirty_wb_cycle: got %0d want 13", wb_cyc); end
    n_chk++; if (wb_bad !== 0) begin n_fail++; $display("FAIL dirty_wb_addr: got %0d bad want 0", wb_bad); end
    n_chk++; if (invs !== 1) begin n_fail++; $display("FAIL dirty_invs: got %0d want 1", invs); end
    n_chk++; if (inv_cyc !== 21) begin n_fail++; $display("FAIL dirty_inv_cycle: got %0d want 21", inv_cyc); end
    n_chk++; if (inv_bad !== 0) begin n_fail++; $display("FAIL dirty_inv_addr: got %0d bad want 0", inv_bad); end
    n_chk++; if (reads !== 8 || rd_bad !== 0) begin n_fail++; $display("FAIL dirty_reads: got %0d/%0d bad want 8/0", reads, rd_bad); end
    n_chk++; if (ack1 !== 26) begin n_fail++; $display("FAIL dirty_ack_cycle: got %0d want 26", ack1); end
    n_chk++; if (dirty_cnt_o !== DC1) begin n_fail++; $display("FAIL dirty_cnt: got %0d want %0d", dirty_cnt_o, DC1); end
  endtask
  task automatic test_gnt_stall();
    lv = '0; ld = '0;
    walk(26, 0, -1, 5, 9, -1, -1, -1);
    n_chk++; if (stall !== 5) begin n_fail++; $display("FAIL stall_cycles: got %0d want 5", stall); end
    n_chk++; if (reads !== 8 || rd_bad !== 0) begin n_fail++; $display("FAIL stall_reads: got %0d/%0d bad want 8/0", reads, rd_bad); end
    n_chk++; if (ack1 !== 22) begin n_fail++; $display("FAIL stall_ack_cycle: got %0d want 22", ack1); end
  endtask
  task automatic test_reset_mid();
    lv = '0; ld = '0; lv[3] = 1'b1; ld[3] = 1'b1;
    walk(20, 0, -1, -1, -1, 9, 13, 11);
    n_chk++; if (wbs !== 1) begin n_fail++; $display("FAIL rmid_wbs: got %0d want 1", wbs); end
    n_chk++; if (invs !== 0) begin n_fail++; $display("FAIL rmid_invs: got %0d want 0", invs); end
    n_chk++; if (acks !== 0) begin n_fail++; $display("FAIL rmid_acks: got %0d want 0", acks); end
    n_chk++; if (post_rst !== 0) begin n_fail++; $display("FAIL rmid_outputs_after_rst: got %0d active cycles want 0", post_rst); end
    lv = '0; ld = '0;
    walk(20, 0, -1, -1, -1, -1, -1, -1);
    n_chk++; if (reads !== 8 || rd_bad !== 0) begin n_fail++; $display("FAIL rmid_restart_reads: got %0d/%0d bad want 8/0", reads, rd_bad); end
    n_chk++; if (ack1 !== 17) begin n_fail++; $display("FAIL rmid_restart_ack: got %0d want 17", ack1); end
  endtask
  task automatic test_back_to_back();
    lv = '0; ld = '0;
    walk(40, 38, -1, -1, -1, -1, -1, -1);
    n_chk++; if (ack1 !== 17) begin n_fail++; $display("FAIL b2b_ack1: got %0d want 17", ack1); end
    n_chk++; if (idle1 !== 18) begin n_fail++; $display("FAIL b2b_idle: got %0d want 18", idle1); end
    n_chk++; if (ack2 !== 35) begin n_fail++; $display("FAIL b2b_ack2: got %0d want 35", ack2); end
    n_chk++; if (acks !== 2) begin n_fail++; $display("FAIL b2b_acks: got %0d want 2", acks); end
    rst_i = 1; step(); rst_i = 0; step();
    walk(30, 0, 8, -1, -1, -1, -1, -1);
    n_chk++; if (acks !== 1) begin n_fail++; $display("FAIL pulse_acks: got %0d want 1", acks); end
    n_chk++; if (reads !== 8) begin n_fail++; $display("FAIL pulse_reads: got %0d want 8", reads); end
    n_chk++; if (ack1 !== 17) begin n_fail++; $display("FAIL pulse_ack_cycle: got %0d want 17", ack1); end
  endtask
  initial begin
    test_reset();
    test_invalid();
    test_clean();
    test_dirty();
    test_gnt_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_flush_ctrl.md
Name: dcache_flush_ctrl

Overview:
- Sequences a full flush of the write-back data cache: walks every set/way, writes back dirty lines, invalidates valid lines.
- Sits between the controller's fence/flush request and the WB dcache tag array and eviction unit.
- Sized for the default 32 KiB, 8-way, 128-bit-line configuration (256 sets).

Parameters:
NumSets, 256, number of cache sets; power of two, >=2
NumWays, 8, associativity; power of two, >=2
IdxW, $clog2(NumSets), set index width (derived, not overridable)
WayW, $clog2(NumWays), way index width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_req_i  in  1  flush request (level); sampled only in IDLE
flush_ack_o  out  1  one-cycle pulse, flush complete
busy_o  out  1  flush in progress
tag_req_o  out  1  tag read request
tag_gnt_i  in  1  tag read grant
tag_idx_o  out  IdxW  set index for tag read/writeback/invalidate
tag_way_o  out  WayW  way index for tag read/writeback/invalidate
tag_rvalid_i  in  1  tag read data valid
tag_valid_i  in  1  line valid bit; qualified by tag_rvalid_i
tag_dirty_i  in  1  line dirty bit; qualified by tag_rvalid_i
wb_valid_o  out  1  writeback request for line at tag_idx_o/tag_way_o
wb_ready_i  in  1  eviction unit accepts writeback
wb_done_i  in  1  writeback data fully sent
inv_o  out  1  invalidate line at tag_idx_o/tag_way_o; always accepted
dirty_cnt_o  out  16  dirty lines written back in last flush (optional feature)

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset: state IDLE, set/way counters 0, all outputs 0.
- States: IDLE, READ_TAG, WAIT_TAG, WRITEBACK, WAIT_WB, INVALIDATE, DONE.
- IDLE: if flush_req_i=1, clear both counters and go to READ_TAG.
- READ_TAG: tag_req_o=1. On tag_gnt_i=1, go to WAIT_TAG.
- WAIT_TAG: waits for tag_rvalid_i=1, then:
  - valid=0: advance directly, with no invalidate.
  - valid=1, dirty=0: go to INVALIDATE.
  - valid=1, dirty=1: go to WRITEBACK.
- WRITEBACK: wb_valid_o=1, held until wb_ready_i=1, then go to WAIT_WB.
- WAIT_WB: on wb_done_i=1, go to INVALIDATE. A wb_done_i in any other state is ignored.
- INVALIDATE: inv_o=1 for exactly one cycle, then advance.
- Advance:
  - If way==NumWays-1 and set==NumSets-1, go to DONE.
  - Otherwise increment the way. On way wrap to 0, increment the set. Go to READ_TAG.
- Iteration order: way inner, set outer (set0 way0, set0 way1, ...).
- DONE: flush_ack_o=1 for one cycle, then IDLE.
- busy_o = (state != IDLE), registered with the state.
- tag_idx_o/tag_way_o equal the counters. They hold stable from READ_TAG until advance.
- Counters are unsigned and wrap naturally at their width. The terminal check uses the explicit last set/way values.
- Timing: with gnt/rvalid same-cycle-available, an invalid line costs 2 cycles and a clean valid line costs 3 cycles.
- flush_req_i while busy: ignored, not queued. If still high when IDLE is re-entered after DONE, a new flush starts.
- Reset mid-flush: immediate return to IDLE. No flush_ack_o, no further wb_valid_o or inv_o. Lines already processed stay processed.
- tag_gnt_i or tag_rvalid_i outside their states: ignored.

Optional Feature:
- Macro: DCACHE_FLUSH_STATS_EN.
- Defined:
  - Internal 16-bit counter, cleared on flush start (IDLE→READ_TAG) and on reset.
  - Increments on each WRITEBACK→WAIT_WB transition and saturates at 16'hFFFF.
  - dirty_cnt_o shows the counter, which holds after DONE until the next flush start.
- Undefined: dirty_cnt_o tied to 0 and no counter logic.

Test Plan:
- Setup: NumSets=4, NumWays=2; tag_gnt_i=1; tag_rvalid_i returns 1 the cycle after gnt.
- All lines invalid; flush_req_i pulsed in cycle 0 → READ_TAG in cycle 1, 8 tag reads over idx/way (0,0),(0,1),(1,0)…(3,1), no inv_o/wb_valid_o, flush_ack_o in cycle 17, busy_o low in cycle 18.
- All lines valid clean → 8 inv_o pulses, each with idx/way matching the preceding tag read; flush_ack_o in cycle 25.
- Line (2,1) valid dirty, wb_ready_i delayed 3 cycles, wb_done_i 4 cycles later → wb_valid_o held 4 cycles with idx=2 way=1, then inv_o on (2,1), walk resumes at (3,0); with DCACHE_FLUSH_STATS_EN, dirty_cnt_o=1.
- tag_gnt_i held low 5 cycles at (1,0) → tag_req_o stays high with idx/way stable, no advance.
- rst_i asserted while in WAIT_WB at (1,1) → next cycle IDLE, all outputs 0, no flush_ack_o, late wb_done_i ignored; a new flush_req_i restarts at (0,0).
- flush_req_i held high throughout → a second flush starts the cycle after DONE returns to IDLE; a second request pulse mid-flush produces no extra flush.
